// File: rtl/div_unit_allocator.sv
// Divider pool allocator: round-robin grant of free dividers to issue lanes and a
// per-unit IDLE/BUSY/DONE sequencer that holds each result until writeback acks it.
module div_unit_allocator #(
  parameter int DIV_UNIT_NUM = 2,
  parameter int REQ_NUM      = 2,
  parameter int DIV_LATENCY  = 34,
  parameter int TAG_WIDTH    = 7,
  localparam int UW = (DIV_UNIT_NUM > 1) ? $clog2(DIV_UNIT_NUM) : 1,
  localparam int RW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
  localparam int CW = $clog2(DIV_LATENCY)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic [REQ_NUM-1:0]             req,
  input  logic [REQ_NUM*TAG_WIDTH-1:0]   reqTag,
  output logic [REQ_NUM-1:0]             grant,
  output logic [REQ_NUM*UW-1:0]          grantUnit,
  output logic [DIV_UNIT_NUM-1:0]        divStart,
  output logic [DIV_UNIT_NUM-1:0]        divFree,
  output logic                           anyFree,
  input  logic                           flushAll,
  output logic [DIV_UNIT_NUM-1:0]        resultValid,
  output logic [DIV_UNIT_NUM*TAG_WIDTH-1:0] resultTag,
  input  logic [DIV_UNIT_NUM-1:0]        resultAck
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } unit_state_e;

  unit_state_e                           state_r     [DIV_UNIT_NUM];
  unit_state_e                           state_nxt_s [DIV_UNIT_NUM];
  logic [DIV_UNIT_NUM-1:0][CW-1:0]        cnt_r, cnt_nxt_s;
  logic [DIV_UNIT_NUM-1:0][TAG_WIDTH-1:0] tag_r, tag_nxt_s;
  logic [RW-1:0]                          rr_ptr_r, rr_nxt_s;
  logic [DIV_UNIT_NUM-1:0]                div_start_r;

  logic [REQ_NUM-1:0][TAG_WIDTH-1:0]      req_tag_s;
  logic [REQ_NUM-1:0][UW-1:0]             grant_unit_s;
  logic [REQ_NUM-1:0]                     grant_s;
  logic [DIV_UNIT_NUM-1:0]                free_s, avail_s, unit_grant_s;
  logic [DIV_UNIT_NUM-1:0][TAG_WIDTH-1:0] unit_tag_s;
  logic [RW-1:0]                          last_lane_s;
  logic                                   any_grant_s, taken_s;

  assign req_tag_s = reqTag;

  // Unit status decode from registered state only.
  always_comb begin
    free_s      = '0;
    resultValid = '0;
    for (int u = 0; u < DIV_UNIT_NUM; u++) begin
      free_s[u]      = (state_r[u] == IDLE);
      resultValid[u] = (state_r[u] == DONE);
    end
  end

  assign divFree   = free_s;
  assign anyFree   = |free_s;
  assign divStart  = div_start_r;
  assign resultTag = tag_r;
  assign grant     = grant_s;
  assign grantUnit = grant_unit_s;

  // Lane scan from rrPtr with wrap (pass 0: lanes >= rrPtr, pass 1: the rest); lowest free unit wins.
  always_comb begin
    grant_s      = '0;
    grant_unit_s = '0;
    unit_grant_s = '0;
    unit_tag_s   = '0;
    avail_s      = free_s;
    last_lane_s  = '0;
    any_grant_s  = 1'b0;
    taken_s      = 1'b0;
    if (rst && !stall && !flushAll) begin
      for (int p = 0; p < 2; p++) begin
        for (int l = 0; l < REQ_NUM; l++) begin
          if (((p == 0) == (l >= int'(rr_ptr_r))) && req[l]) begin
            taken_s = 1'b0;
            for (int u = 0; u < DIV_UNIT_NUM; u++) begin
              if (avail_s[u] && !taken_s) begin
                taken_s         = 1'b1;
                avail_s[u]      = 1'b0;
                grant_s[l]      = 1'b1;
                grant_unit_s[l] = UW'(u);
                unit_grant_s[u] = 1'b1;
                unit_tag_s[u]   = req_tag_s[l];
                last_lane_s     = RW'(l);
                any_grant_s     = 1'b1;
              end else begin
                taken_s = taken_s;
              end
            end
          end else begin
            any_grant_s = any_grant_s;
          end
        end
      end
    end else begin
      grant_s = '0;
    end
  end

  // Round-robin pointer moves past the last granted lane; held when nothing is granted.
  always_comb begin
    rr_nxt_s = rr_ptr_r;
    if (any_grant_s) begin
      if (int'(last_lane_s) == REQ_NUM - 1) begin
        rr_nxt_s = '0;
      end else begin
        rr_nxt_s = last_lane_s + RW'(1);
      end
    end else begin
      rr_nxt_s = rr_ptr_r;
    end
  end

  // Per-unit next-state: flush forces IDLE from any state; ack outside DONE is ignored.
  always_comb begin
    for (int u = 0; u < DIV_UNIT_NUM; u++) begin
      state_nxt_s[u] = state_r[u];
      cnt_nxt_s[u]   = cnt_r[u];
      tag_nxt_s[u]   = tag_r[u];
      if (flushAll) begin
        state_nxt_s[u] = IDLE;
        cnt_nxt_s[u]   = '0;
      end else begin
        case (state_r[u])
          IDLE: begin
            if (unit_grant_s[u]) begin
              state_nxt_s[u] = BUSY;
              cnt_nxt_s[u]   = CW'(DIV_LATENCY - 1);
              tag_nxt_s[u]   = unit_tag_s[u];
            end else begin
              state_nxt_s[u] = IDLE;
            end
          end
          BUSY: begin
            if (cnt_r[u] == '0) begin
              state_nxt_s[u] = DONE;
            end else begin
              cnt_nxt_s[u] = cnt_r[u] - CW'(1);
            end
          end
          DONE: begin
            if (resultAck[u]) begin
              state_nxt_s[u] = IDLE;
            end else begin
              state_nxt_s[u] = DONE;
            end
          end
          default: begin
            state_nxt_s[u] = IDLE;
          end
        endcase
      end
    end
  end

  // State, counter, tag, pointer and start-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int u = 0; u < DIV_UNIT_NUM; u++) begin
        state_r[u] <= IDLE;
      end
      cnt_r       <= '0;
      tag_r       <= '0;
      rr_ptr_r    <= '0;
      div_start_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      tag_r       <= tag_nxt_s;
      rr_ptr_r    <= rr_nxt_s;
      div_start_r <= unit_grant_s;
    end
  end

endmodule

// File: tb/tb_div_unit_allocator.sv
// Scenario bench for div_unit_allocator with per-unit expected-tag queues.
module tb_div_unit_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  req;
  logic [13:0] reqTag;
  logic [1:0]  grant;
  logic [1:0]  grantUnit;
  logic [1:0]  divStart;
  logic [1:0]  divFree;
  logic        anyFree;
  logic        flushAll;
  logic [1:0]  resultValid;
  logic [13:0] resultTag;
  logic [1:0]  resultAck;

  int vectors = 0;
  int miscompares = 0;
  logic [6:0] sb0[$];
  logic [6:0] sb1[$];

  always #5 clk = ~clk;

  div_unit_allocator #(
    .DIV_UNIT_NUM(2), .REQ_NUM(2), .DIV_LATENCY(34), .TAG_WIDTH(7)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .req(req), .reqTag(reqTag),
    .grant(grant), .grantUnit(grantUnit), .divStart(divStart), .divFree(divFree),
    .anyFree(anyFree), .flushAll(flushAll), .resultValid(resultValid),
    .resultTag(resultTag), .resultAck(resultAck)
  );

  task automatic apply_reset();
    rst = 1'b0; stall = 1'b0; req = 2'b00; reqTag = 14'd0; flushAll = 1'b0; resultAck = 2'b00;
    sb0.delete(); sb1.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; req = 2'b11; reqTag = {7'd9, 7'd8};
    #1;
    vectors++; if (divFree !== 2'b11) begin miscompares++; $display("FAIL reset_divFree got %b exp 11", divFree); end
    vectors++; if (anyFree !== 1'b1) begin miscompares++; $display("FAIL reset_anyFree got %b exp 1", anyFree); end
    vectors++; if (resultValid !== 2'b00) begin miscompares++; $display("FAIL reset_resultValid got %b exp 00", resultValid); end
    vectors++; if (divStart !== 2'b00) begin miscompares++; $display("FAIL reset_divStart got %b exp 00", divStart); end
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL reset_grant got %b exp 00", grant); end
    vectors++; if (resultTag !== 14'd0) begin miscompares++; $display("FAIL reset_resultTag got %h exp 0", resultTag); end
    req = 2'b00;
  endtask

  task automatic test_single_op();
    int cyc;
    logic [6:0] exp_tag;
    apply_reset();
    req = 2'b01; reqTag = {7'd0, 7'd5};
    sb0.push_back(7'd5);
    #1;
    vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL single_grant got %b exp 01", grant); end
    vectors++; if (grantUnit[0] !== 1'b0) begin miscompares++; $display("FAIL single_unit got %b exp 0", grantUnit[0]); end
    @(negedge clk);
    req = 2'b00;
    vectors++; if (divStart !== 2'b01) begin miscompares++; $display("FAIL single_divStart got %b exp 01", divStart); end
    vectors++; if (divFree !== 2'b10) begin miscompares++; $display("FAIL single_busyFree got %b exp 10", divFree); end
    @(negedge clk);
    vectors++; if (divStart !== 2'b00) begin miscompares++; $display("FAIL single_startPulse got %b exp 00", divStart); end
    cyc = 2;
    while (!resultValid[0] && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    vectors++; if (cyc !== 35) begin miscompares++; $display("FAIL single_latency got %0d exp 35", cyc); end
    vectors++;
    if (sb0.size() == 0) begin
      miscompares++; $display("FAIL single_sb got empty exp entry");
    end else begin
      exp_tag = sb0.pop_front();
      if (resultTag[6:0] !== exp_tag) begin miscompares++; $display("FAIL single_tag got %0d exp %0d", resultTag[6:0], exp_tag); end
    end
    resultAck = 2'b01;
    @(negedge clk);
    resultAck = 2'b00;
    vectors++; if (divFree !== 2'b11) begin miscompares++; $display("FAIL single_freeAfterAck got %b exp 11", divFree); end
    vectors++; if (resultValid !== 2'b00) begin miscompares++; $display("FAIL single_validAfterAck got %b exp 00", resultValid); end
  endtask

  task automatic test_dual();
    int cyc;
    apply_reset();
    req = 2'b11; reqTag = {7'd11, 7'd10};
    sb0.push_back(7'd10); sb1.push_back(7'd11);
    #1;
    vectors++; if (grant !== 2'b11) begin miscompares++; $display("FAIL dual_grant got %b exp 11", grant); end
    vectors++; if (grantUnit !== 2'b10) begin miscompares++; $display("FAIL dual_units got %b exp 10", grantUnit); end
    @(negedge clk);
    req = 2'b01;
    #1;
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL dual_noFreeGrant got %b exp 00", grant); end
    vectors++; if (anyFree !== 1'b0) begin miscompares++; $display("FAIL dual_anyFree got %b exp 0", anyFree); end
    vectors++; if (divStart !== 2'b11) begin miscompares++; $display("FAIL dual_divStart got %b exp 11", divStart); end
    req = 2'b00;
    cyc = 0;
    while (resultValid !== 2'b11 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    vectors++; if (resultValid !== 2'b11) begin miscompares++; $display("FAIL dual_done got %b exp 11", resultValid); end
    vectors++;
    if (sb0.size() == 0 || sb1.size() == 0) begin
      miscompares++; $display("FAIL dual_sb got empty exp entries");
    end else begin
      if (resultTag !== {sb1.pop_front(), sb0.pop_front()}) begin
        miscompares++; $display("FAIL dual_tags got %h exp %h", resultTag, {7'd11, 7'd10});
      end
    end
    resultAck = 2'b11;
    @(negedge clk);
    resultAck = 2'b00;
    vectors++; if (divFree !== 2'b11) begin miscompares++; $display("FAIL dual_freeAfterAck got %b exp 11", divFree); end
  endtask

  task automatic test_round_robin();
    int cyc;
    int n;
    logic exp_lane;
    logic [6:0] exp_tag;
    apply_reset();
    req = 2'b11; reqTag = {7'd40, 7'd20};
    sb0.push_back(7'd20); sb1.push_back(7'd40);
    @(negedge clk);
    req = 2'b00;
    cyc = 0;
    while (resultValid !== 2'b11 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    vectors++; if (resultValid !== 2'b11) begin miscompares++; $display("FAIL rr_setup got %b exp 11", resultValid); end
    exp_lane = 1'b0; n = 0; cyc = 0;
    while (n < 4 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      req = 2'b11; reqTag = {7'd40 + 7'(n), 7'd20 + 7'(n)}; resultAck = 2'b00;
      if (resultValid[0]) begin
        vectors++;
        if (sb0.size() == 0) begin
          miscompares++; $display("FAIL rr_sb got empty exp entry");
        end else begin
          exp_tag = sb0.pop_front();
          if (resultTag[6:0] !== exp_tag) begin miscompares++; $display("FAIL rr_tag got %0d exp %0d", resultTag[6:0], exp_tag); end
        end
        resultAck = 2'b01;
      end
      #1;
      if (grant !== 2'b00) begin
        vectors++;
        if (grant !== (exp_lane ? 2'b10 : 2'b01)) begin
          miscompares++; $display("FAIL rr_order got %b exp lane %0d", grant, exp_lane);
        end
        vectors++;
        if (grantUnit[exp_lane] !== 1'b0) begin miscompares++; $display("FAIL rr_unit got %b exp 0", grantUnit[exp_lane]); end
        sb0.push_back(exp_lane ? (7'd40 + 7'(n)) : (7'd20 + 7'(n)));
        exp_lane = ~exp_lane;
        n++;
      end
    end
    req = 2'b00; resultAck = 2'b00;
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL rr_grantCount got %0d exp 4", n); end
    vectors++;
    if (sb1.size() == 0) begin
      miscompares++; $display("FAIL rr_heldSb got empty exp entry");
    end else begin
      exp_tag = sb1.pop_front();
      if (resultValid[1] !== 1'b1 || resultTag[13:7] !== exp_tag) begin
        miscompares++; $display("FAIL rr_heldUnit got v=%b tag=%0d exp v=1 tag=%0d", resultValid[1], resultTag[13:7], exp_tag);
      end
    end
  endtask

  task automatic test_flush();
    int bad;
    apply_reset();
    req = 2'b11; reqTag = {7'd3, 7'd2};
    @(negedge clk);
    req = 2'b00;
    repeat (9) @(negedge clk);
    flushAll = 1'b1; req = 2'b11;
    #1;
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL flush_grant got %b exp 00", grant); end
    @(negedge clk);
    flushAll = 1'b0; req = 2'b00;
    vectors++; if (divFree !== 2'b11) begin miscompares++; $display("FAIL flush_idle got %b exp 11", divFree); end
    vectors++; if (divStart !== 2'b00) begin miscompares++; $display("FAIL flush_divStart got %b exp 00", divStart); end
    bad = 0;
    repeat (29) begin
      @(negedge clk);
      if (resultValid !== 2'b00) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL flush_noResult got %0d cycles exp 0", bad); end
    flushAll = 1'b1; req = 2'b11;
    #1;
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL flush_idleGrant got %b exp 00", grant); end
    @(negedge clk);
    flushAll = 1'b0; req = 2'b00;
    vectors++; if (divStart !== 2'b00) begin miscompares++; $display("FAIL flush_startSuppress got %b exp 00", divStart); end
    vectors++; if (divFree !== 2'b11) begin miscompares++; $display("FAIL flush_stillFree got %b exp 11", divFree); end
  endtask

  task automatic test_hold();
    int cyc;
    int gcount;
    logic [6:0] exp_tag;
    apply_reset();
    req = 2'b01; reqTag = {7'd0, 7'h55};
    sb0.push_back(7'h55);
    @(negedge clk);
    req = 2'b00;
    cyc = 0;
    while (!resultValid[0] && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (sb0.size() == 0) begin
      miscompares++; $display("FAIL hold_sb got empty exp entry");
      exp_tag = 7'h55;
    end else begin
      exp_tag = sb0.pop_front();
      if (resultValid[0] !== 1'b1) begin miscompares++; $display("FAIL hold_done got %b exp 1", resultValid[0]); end
    end
    gcount = 0;
    for (int i = 0; i < 20; i++) begin
      req = 2'b01; reqTag = {7'd0, 7'h11};
      #1;
      vectors++; if (resultValid[0] !== 1'b1) begin miscompares++; $display("FAIL hold_valid got %b exp 1", resultValid[0]); end
      vectors++; if (resultTag[6:0] !== exp_tag) begin miscompares++; $display("FAIL hold_tag got %0d exp %0d", resultTag[6:0], exp_tag); end
      vectors++; if (divFree[0] !== 1'b0) begin miscompares++; $display("FAIL hold_free got %b exp 0", divFree[0]); end
      if (grant[0]) begin
        gcount++;
        vectors++; if (grantUnit[0] !== 1'b1) begin miscompares++; $display("FAIL hold_unit got %b exp 1", grantUnit[0]); end
      end
      @(negedge clk);
    end
    req = 2'b00;
    vectors++; if (gcount !== 1) begin miscompares++; $display("FAIL hold_grantCount got %0d exp 1", gcount); end
    resultAck = 2'b01;
    @(negedge clk);
    resultAck = 2'b00;
    vectors++; if (divFree[0] !== 1'b1) begin miscompares++; $display("FAIL hold_freeAfterAck got %b exp 1", divFree[0]); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 2'b11; reqTag = {7'd7, 7'd6};
    @(negedge clk);
    req = 2'b00;
    repeat (3) @(negedge clk);
    vectors++; if (divFree !== 2'b00) begin miscompares++; $display("FAIL areset_busy got %b exp 00", divFree); end
    #2;
    rst = 1'b0;
    #1;
    vectors++; if (divFree !== 2'b11) begin miscompares++; $display("FAIL areset_free got %b exp 11", divFree); end
    vectors++; if (anyFree !== 1'b1) begin miscompares++; $display("FAIL areset_anyFree got %b exp 1", anyFree); end
    vectors++; if (resultValid !== 2'b00) begin miscompares++; $display("FAIL areset_valid got %b exp 00", resultValid); end
    vectors++; if (resultTag !== 14'd0) begin miscompares++; $display("FAIL areset_tag got %h exp 0", resultTag); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; req = 2'b00; reqTag = 14'd0; flushAll = 1'b0; resultAck = 2'b00;
    test_reset();
    test_dual();
    test_single_op();
    test_round_robin();
    test_flush();
    test_hold();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_unit_allocator.md
# div_unit_allocator

Allocates a pool of iterative integer dividers to div ops issued from the complex/mem issue lanes, sequences each divider through its multi-cycle operation, and holds its result until writeback accepts it. Sits between issue-queue select and the divider datapath. Supplies the per-unit free status that gates div issue requests in the scheduler. Kills in-flight divisions on pipeline flush.

## Interface
- `DIV_UNIT_NUM`, 2: number of divider units in the pool.
- `REQ_NUM`, 2: number of issue lanes that can request a divider.
- `DIV_LATENCY`, 34: cycles a unit stays BUSY per operation; must be ≥2.
- `TAG_WIDTH`, 7: width of the op tag (active-list pointer) carried with each division.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall`  in  1  issue stall; while high, no grants.
- `req`  in  REQ_NUM  lane r requests a divider this cycle.
- `reqTag`  in  REQ_NUM×TAG_WIDTH  tag of lane r's op.
- `grant`  out  REQ_NUM  lane r granted (combinational, same cycle as req).
- `grantUnit`  out  REQ_NUM×clog2(DIV_UNIT_NUM)  unit assigned to lane r; valid only when grant[r].
- `divStart`  out  DIV_UNIT_NUM  one-cycle registered pulse to datapath unit u: load operands.
- `divFree`  out  DIV_UNIT_NUM  unit u is IDLE.
- `anyFree`  out  1  OR of divFree.
- `flushAll`  in  1  kill every in-flight division.
- `resultValid`  out  DIV_UNIT_NUM  unit u is in DONE.
- `resultTag`  out  DIV_UNIT_NUM×TAG_WIDTH  tag held by unit u.
- `resultAck`  in  DIV_UNIT_NUM  writeback consumed unit u's result.

## Operation
- Per-unit FSM: IDLE → BUSY → DONE → IDLE.
  - IDLE: on grant to this unit, latch tag, load counter with DIV_LATENCY−1, go BUSY.
  - BUSY: decrement counter each cycle; when counter==0, go DONE.
  - DONE: resultValid high, tag stable; on resultAck go IDLE.
- Counter width clog2(DIV_LATENCY); never wraps (no decrement at 0).
- Grant allocation each cycle, when stall==0 and flushAll==0:
  - Requesters scanned in round-robin order starting at rrPtr; free units assigned lowest-index-first.
  - Grant count = min(number of requests, number of IDLE units). A unit freed by resultAck this cycle is not available until next cycle.
  - rrPtr advances to (last granted lane + 1) mod REQ_NUM. Unchanged if no grant.
- divStart[u] is registered: high in the cycle after unit u is granted, coincident with the first BUSY cycle.
- flushAll: every unit goes to IDLE next cycle, from any state. No grants in that cycle. divStart is suppressed next cycle. rrPtr is held.
- resultAck to a unit not in DONE is ignored.
- Reset (async, rst=0): all units IDLE, counters 0, tags 0, rrPtr 0. Outputs during and after reset: divFree all 1, anyFree 1, resultValid 0, divStart 0, grant 0, resultTag 0.
- Reset asserted mid-operation discards the in-flight state immediately.

## Timing
- Grant in cycle T (req high, unit IDLE): divStart and BUSY in T+1 … T+DIV_LATENCY.
- DONE and resultValid from T+DIV_LATENCY+1.
- Ack in cycle D: IDLE in D+1, divFree=1 in D+1, re-grantable in D+1.
- Minimum back-to-back issue interval per unit: DIV_LATENCY+2 cycles, with same-cycle ack.
- divFree/anyFree reflect registered state only; no combinational path from req or resultAck.
- grant depends combinationally on req, stall, flushAll, registered state.

## Test plan
- Single op: reset, req[0]=1 tag 5 at T → grant[0]=1 and grantUnit=0 at T; divStart[0]=1 at T+1; resultValid[0]=1 with resultTag=5 at T+35 (DIV_LATENCY=34); ack at T+35 → divFree[0]=1 at T+36.
- Dual request, both units free: req=2'b11 → both granted; lane0→unit0, lane1→unit1. Next cycle req=2'b01 → grant=0 and anyFree=0.
- Round-robin with one free unit: both lanes request continuously while one unit recycles → grants alternate lane0, lane1, lane0, …
- Flush mid-BUSY: grant at T, flushAll at T+10 → both units IDLE at T+11; no resultValid through T+40; grant=0 during flush cycle even with req.
- Result held without ack: no resultAck for 20 cycles → resultValid and resultTag stable, divFree=0, new request to that unit not granted.
- Async reset in BUSY: drop rst between clock edges → divFree=all 1 and resultValid=0 immediately, before the next clock edge.
